// File: rtl/pe_macc_seq.sv
// Sequencing controller for one PE multiply-accumulate datapath: job intake, operand
// handshake, partial-sum feedback and result return. Define PE_MACC_SEQ_SAT_EN to clamp results.
module pe_macc_seq #(
    parameter int SIZEIN  = 16,
    parameter int SIZEOUT = 40,
    parameter int LEN_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      job_valid,
    output logic                      job_ready,
    input  logic [LEN_W-1:0]          job_len,
    input  logic                      job_use_ext,
    input  logic signed [SIZEIN-1:0]  job_ext_psum,
    input  logic                      op_valid,
    output logic                      op_ready,
    output logic                      res_valid,
    input  logic                      res_ready,
    output logic signed [SIZEOUT-1:0] res_data,
    output logic                      res_ovf,
    output logic                      busy,
    output logic                      macc_gate,
    output logic                      macc_exter,
    output logic                      macc_clear,
    output logic signed [SIZEOUT-1:0] macc_psum,
    input  logic signed [SIZEOUT-1:0] macc_accum
);

    typedef enum logic [2:0] {IDLE, LOAD, RUN, DRAIN, DONE} state_t;

    state_t                    state, state_nx;
    logic [LEN_W-1:0]          cnt;
    logic                      pv;
    logic                      first;
    logic                      beat;
    logic signed [SIZEOUT-1:0] psum_q;
    logic signed [SIZEOUT-1:0] fin_data;
    logic                      fin_ovf;

    // The seed travels straight to the datapath; this block only times its selection.
    logic unused_seed;
    assign unused_seed = ^job_ext_psum;

    always_comb begin
        state_nx   = state;
        job_ready  = 1'b0;
        op_ready   = 1'b0;
        macc_gate  = 1'b1;
        macc_exter = 1'b0;
        beat       = 1'b0;
        case (state)
            IDLE: begin
                job_ready = 1'b1;
                if (job_valid) begin
                    if (job_use_ext)
                        state_nx = LOAD;
                    else if (job_len != '0)
                        state_nx = RUN;
                    else
                        state_nx = DRAIN;
                end
            end
            LOAD: begin
                macc_exter = 1'b1;
                state_nx   = (cnt == '0) ? DRAIN : RUN;
            end
            RUN: begin
                op_ready  = (cnt != '0);
                beat      = op_valid && op_ready;
                macc_gate = !beat;
                if (beat && cnt == LEN_W'(1))
                    state_nx = DRAIN;
            end
            DRAIN: begin
                if (!pv)
                    state_nx = DONE;
            end
            DONE: begin
                if (res_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // First captured term clears adder input A so stale psum never leaks into a new job.
    assign macc_clear = !pv || first;
    assign macc_psum  = psum_q;
    assign busy       = (state != IDLE);
    assign res_valid  = (state == DONE);

`ifdef PE_MACC_SEQ_SAT_EN
    localparam logic signed [SIZEOUT-1:0] SAT_MAX = {{(SIZEOUT-SIZEIN+1){1'b0}}, {(SIZEIN-1){1'b1}}};
    localparam logic signed [SIZEOUT-1:0] SAT_MIN = {{(SIZEOUT-SIZEIN+1){1'b1}}, {(SIZEIN-1){1'b0}}};

    always_comb begin
        fin_data = first ? '0 : psum_q;
        fin_ovf  = 1'b0;
        if (fin_data > SAT_MAX) begin
            fin_data = SAT_MAX;
            fin_ovf  = 1'b1;
        end else if (fin_data < SAT_MIN) begin
            fin_data = SAT_MIN;
            fin_ovf  = 1'b1;
        end
    end
`else
    always_comb begin
        fin_data = first ? '0 : psum_q;
        fin_ovf  = 1'b0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            psum_q   <= '0;
            pv       <= 1'b0;
            first    <= 1'b0;
            cnt      <= '0;
            res_data <= '0;
            res_ovf  <= 1'b0;
        end else begin
            state <= state_nx;
            pv    <= (state == LOAD) || beat;
            if (pv) begin
                psum_q <= macc_accum;
                first  <= 1'b0;
            end
            if (state == IDLE && job_valid) begin
                cnt   <= job_len;
                first <= 1'b1;
            end
            if (beat)
                cnt <= cnt - LEN_W'(1);
            // first still set here means nothing was captured: empty job yields zero.
            if (state == DRAIN && !pv) begin
                res_data <= fin_data;
                res_ovf  <= fin_ovf;
            end
        end
    end

endmodule
